aqp_ovl_font_ctrl: RTL

//  Access controller for the overlay font RAM (2048x8, registered read, one clock here).
//  - Read port: shared between the overlay text renderer (fixed priority) and CPU read-back.
//  - Write port: shared between CPU writes and a bulk-fill engine that clears/fills the whole font.
//  - Sits between the overlay renderer/CPU register file and the font RAM instance.

---
 rtl/aqp_ovl_font_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aqp_ovl_font_ctrl.sv
// Overlay font RAM access controller: renderer/CPU read arbitration and a
// CPU-write / bulk-fill write path driving a 2-port font RAM.
module aqp_ovl_font_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_rd_en,
  input  logic [ADDR_W-1:0] vid_rdaddr,
  output logic [DATA_W-1:0] vid_rddata,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_ack,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_wrdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [DATA_W-1:0] ram_rddata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Read path state
  logic              rd_pend_q, rd_pend_d;
  logic              rd_ack_q,  rd_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Write path state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              done_q, done_d;

  // The renderer owns the read port whenever it asks; the CPU gets the idle slots.
  assign ram_rdaddr = vid_rd_en ? vid_rdaddr : cpu_rd_addr;
  assign vid_rddata = ram_rddata;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    rd_pend_d = cpu_rd_req && !vid_rd_en && !rd_pend_q && !rd_ack_q;
    rd_ack_d  = rd_pend_q;
    rd_data_d = rd_data_q;
    if (rd_pend_q) rd_data_d = ram_rddata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    wren_d     = 1'b0;
    wraddr_d   = wraddr_q;
    wrdata_d   = wrdata_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_wr) begin
          wren_d   = 1'b1;
          wraddr_d = cpu_wr_addr;
          wrdata_d = cpu_wr_data;
        end
        if (fill_start) begin
          fill_val_d = fill_value;
          cnt_d      = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        wren_d   = 1'b1;
        wraddr_d = cnt_q;
        wrdata_d = fill_val_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        // Leave on the last address itself so the counter never wraps into a re-fill.
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      wren_q     <= wren_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
      done_q     <= done_d;
    end
  end

  assign cpu_rd_data  = rd_data_q;
  assign cpu_rd_ack   = rd_ack_q;
  assign fill_busy    = (state_q == S_FILL);
  assign cpu_wr_ready = !fill_busy;
  assign fill_done    = done_q;
  assign ram_wren     = wren_q;
  assign ram_wraddr   = wraddr_q;
  assign ram_wrdata   = wrdata_q;

endmodule
